// File: rtl/approx_div16.sv
// approx_div16: normalise, restoring-divide and denormalise approximate divider.
// Build option APPROX_DIV_ROUND_EN: round half up on right shifts.
module approx_div16 #(
  parameter int W = 16,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [W-1:0] Q
);

  localparam int CW = $clog2(W);
  localparam int EW = $clog2(W + M) + 2;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    DIV,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [W-1:0]  s_a;
  logic [W-1:0]  s_b;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic [M-1:0]  rem;
  logic [W-1:0]  q;
  logic [EW-1:0] step;
  logic          shr;

  logic [M-1:0]  bh;
  logic [M:0]    rem_sh;
  logic [M:0]    rem_sub;
  logic          fit;
  logic [W-1:0]  q_nxt;
  logic [W-1:0]  q_shl;
  logic [W-1:0]  q_shr;
  logic [W-1:0]  q_rnd;
  logic [EW-1:0] e;
  logic [EW-1:0] e_abs;
  logic          e_neg;
  logic          e_zero;
  logic          norm_ok;
  logic          div_last;
  logic          sh_last;

  assign bh      = s_b[W-1:W-M];
  assign rem_sh  = {rem, s_a[W-1]};
  assign rem_sub = rem_sh - {1'b0, bh};
  assign fit     = rem_sh >= {1'b0, bh};
  assign q_nxt   = {q[W-2:0], fit};
  assign q_shl   = {q[W-2:0], 1'b0};
  assign q_shr   = {1'b0, q[W-1:1]};

  // final right shift: the bit leaving q decides rounding
`ifdef APPROX_DIV_ROUND_EN
  assign q_rnd = q_shr + W'(q[0]);
`else
  assign q_rnd = q_shr;
`endif

  assign e      = EW'(cnt_b) - EW'(cnt_a)
                - EW'(M);
  assign e_neg  = e[EW-1];
  assign e_zero = (e == '0);
  assign e_abs  = e_neg ? (~e + EW'(1)) : e;

  assign norm_ok  = s_a[W-1] & s_b[W-1];
  assign div_last = (step == EW'(W - 1));
  assign sh_last  = (step == EW'(1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (B == '0 || A == '0) nxt = DONE;
          else                    nxt = NORM;
        end
      end
      NORM: begin
        if (norm_ok) nxt = DIV;
      end
      DIV: begin
        if (div_last) begin
          if (e_zero) nxt = DONE;
          else        nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sh_last) nxt = DONE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_a         <= '0;
      s_b         <= '0;
      cnt_a       <= '0;
      cnt_b       <= '0;
      rem         <= '0;
      q           <= '0;
      step        <= '0;
      shr         <= 1'b0;
      Q           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            s_a         <= A;
            s_b         <= B;
            cnt_a       <= '0;
            cnt_b       <= '0;
            rem         <= '0;
            q           <= '0;
            step        <= '0;
            shr         <= 1'b0;
            div_by_zero <= (B == '0);
            if (B == '0)      Q <= '1;
            else if (A == '0) Q <= '0;
          end
        end
        NORM: begin
          if (!s_a[W-1]) begin
            s_a   <= {s_a[W-2:0], 1'b0};
            cnt_a <= cnt_a + CW'(1);
          end
          if (!s_b[W-1]) begin
            s_b   <= {s_b[W-2:0], 1'b0};
            cnt_b <= cnt_b + CW'(1);
          end
          // keep only the mantissa as the dividend
          if (norm_ok) begin
            s_a  <= {s_a[W-1:W-M], {(W-M){1'b0}}};
            rem  <= '0;
            q    <= '0;
            step <= '0;
          end
        end
        DIV: begin
          s_a  <= {s_a[W-2:0], 1'b0};
          rem  <= fit ? rem_sub[M-1:0]
                      : rem_sh[M-1:0];
          q    <= q_nxt;
          step <= step + EW'(1);
          if (div_last) begin
            step <= e_abs;
            shr  <= e_neg;
            if (e_zero) Q <= q_nxt;
          end
        end
        SHIFT: begin
          step <= step - EW'(1);
          q    <= shr ? q_shr : q_shl;
          if (sh_last) Q <= shr ? q_rnd : q_shl;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_div16.sv
// tb_approx_div16: randomized and directed checks of approx_div16
// against an arithmetic reference model.
module tb_approx_div16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [15:0] Q;

  int vec;
  int bad;

  approx_div16 #(.W(16), .M(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (op_a),
    .B           (op_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .Q           (Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  function automatic int lz16(input logic [15:0] v);
    for (int i = 15; i >= 0; i--)
      if (v[i]) return 15 - i;
    return 16;
  endfunction

  task automatic model(input  logic [15:0] a,
                       input  logic [15:0] b,
                       output logic [15:0] q_e,
                       output logic        dz_e,
                       output int          lat_e);
    int sa, sb, ah, bh, qq, e, n;
    longint r;
    if (b == 0) begin
      q_e = 16'hFFFF; dz_e = 1'b1; lat_e = 2;
    end else if (a == 0) begin
      q_e = 16'h0; dz_e = 1'b0; lat_e = 2;
    end else begin
      sa = lz16(a);
      sb = lz16(b);
      ah = (int'(a) << sa) >> 8;
      bh = (int'(b) << sb) >> 8;
      qq = (ah * 256) / bh;
      e  = sb - sa - 8;
      if (e >= 0) begin
        r = longint'(qq) << e;
      end else begin
        n = -e;
`ifdef APPROX_DIV_ROUND_EN
        r = (longint'(qq) + (longint'(1) << (n - 1))) >> n;
`else
        r = longint'(qq) >> n;
`endif
      end
      q_e   = r[15:0];
      dz_e  = 1'b0;
      lat_e = 1 + ((sa > sb) ? sa : sb) + 1
            + 16 + ((e < 0) ? -e : e) + 1;
    end
  endtask

  task automatic run_op(input  string       tag,
                        input  logic [15:0] a,
                        input  logic [15:0] b,
                        input  bit          tgl,
                        output int          lat_o);
    logic [15:0] q_e;
    logic        dz_e;
    int          lat_e;
    int          n;
    model(a, b, q_e, dz_e, lat_e);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    check({tag, ":busy"}, 32'(busy), 1);
    while (!done && n < 400) begin
      if (tgl) begin
        start = 1'($urandom_range(0, 1));
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    lat_o = n + 1;
    check({tag, ":done"}, 32'(done), 1);
    check({tag, ":lat"}, lat_o, lat_e);
    check({tag, ":q"}, 32'(Q), 32'(q_e));
    check({tag, ":dz"}, 32'(div_by_zero), 32'(dz_e));
    @(posedge clk);
    #1;
    check({tag, ":pulse"}, 32'(done), 0);
    check({tag, ":hold"}, 32'(Q), 32'(q_e));
  endtask

  initial begin
    int lat;
    logic [15:0] ra, rb;
    vec   = 0;
    bad   = 0;
    rst   = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #12;
    check("rst:q", 32'(Q), 0);
    check("rst:done", 32'(done), 0);
    check("rst:busy", 32'(busy), 0);
    check("rst:dz", 32'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b1;

    run_op("typ", 16'd100, 16'd7, 1'b0, lat);
    check("typ:q14", 32'(Q), 14);
    check("typ:lat36", lat, 36);
    run_op("max", 16'hFFFF, 16'd1, 1'b0, lat);
    check("max:qff00", 32'(Q), 32'hFF00);
    run_op("rnd", 16'd15, 16'd2, 1'b0, lat);
`ifdef APPROX_DIV_ROUND_EN
    check("rnd:q8", 32'(Q), 8);
`else
    check("rnd:q7", 32'(Q), 7);
`endif
    run_op("azero", 16'd0, 16'd9, 1'b0, lat);
    run_op("uflow", 16'd1, 16'hFFFF, 1'b0, lat);
    run_op("equal", 16'h8000, 16'h8000, 1'b0, lat);
    check("equal:q1", 32'(Q), 1);
    check("equal:lat27", lat, 27);
    run_op("tgl", 16'd100, 16'd7, 1'b1, lat);
    run_op("bzero", 16'd5, 16'd0, 1'b0, lat);
    check("bzero:lat2", lat, 2);

    @(negedge clk);
    op_a  = 16'd100;
    op_b  = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort:q", 32'(Q), 0);
    check("abort:dz", 32'(div_by_zero), 0);
    check("abort:busy", 32'(busy), 0);
    check("abort:done", 32'(done), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort:nodone", 32'(done), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    run_op("again", 16'd100, 16'd7, 1'b0, lat);
    check("again:q14", 32'(Q), 14);

    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom_range(0, 65535)
               >> $urandom_range(0, 16));
      rb = 16'($urandom_range(0, 65535)
               >> $urandom_range(0, 16));
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)), lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

endmodule

// File: doc/approx_div16.md
Name: approx_div16

Overview:
- Sequential approximate unsigned divider. It is the inverse counterpart of the team's normalise-truncate-multiply approximate multiplier.
- Both operands are left-normalised with leading-one counters, and their top M bits are divided with a radix-2 restoring divider. The quotient is then de-normalised by a sequential shifter.
- It sits beside the multiplier under a start/done handshake, driven by the same top-level controller.

Parameters:
- W, 16: operand and quotient width.
- M, 8: mantissa bits kept after normalisation.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- A  in  W  dividend; captured on accepted start.
- B  in  W  divisor; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse in DONE.
- div_by_zero  out  1  valid with done; held until the next accepted start.
- Q  out  W  approximate quotient; held until the next accepted start.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE.
  - Q=0, done=0, busy=0, div_by_zero=0.
  - All internal registers and counters cleared.
  - Reset mid-operation aborts the operation; no done is produced.
- IDLE, start=1:
  - Capture A and B into shift registers sA and sB; clear counters cntA and cntB (log2(W) bits each).
  - If B==0: go to DONE with Q=all-ones and div_by_zero=1.
  - Else if A==0: go to DONE with Q=0.
  - Else: go to NORM.
  - start is ignored in every other state.
- NORM, one cycle per step:
  - If sA[W-1]==0: shift sA left by 1 and increment cntA.
  - If sB[W-1]==0: shift sB left by 1 and increment cntB. A and B normalise independently and in parallel.
  - When both MSBs are 1: go to DIV.
  - NORM lasts max(shA,shB)+1 cycles, where shA and shB are the leading-zero counts.
- DIV, exactly W cycles:
  - Restoring division of {sA[W-1:W-M], M zeros} by sB[W-1:W-M]. Each cycle: shift remainder left, trial-subtract, set one quotient bit.
  - Result q = floor(Ah*2^M / Bh). Because both mantissas are >= 2^(M-1), q < 2^(M+1).
- Exponent: e = cntB - cntA - M, signed, range -(W+M-1)..(W-1-M).
- SHIFT, |e| cycles:
  - If e>0: shift q left by 1 per cycle.
  - If e<0: shift q right by 1 per cycle.
  - If e==0: skip SHIFT entirely.
  - Shifting left never overflows W bits (q<2^(M+1), e<=W-1-M).
- DONE, one cycle:
  - done=1; Q is loaded with the result.
  - Next state is IDLE. A new start can be accepted in the cycle after DONE.
- Total latency, start to done, for non-zero operands: 1 (capture) + max(shA,shB)+1 + W + |e| + 1 cycles.
- Latency for a zero operand: 2 cycles.
- start held high continuously: a new operation starts in each IDLE cycle; no back-to-back overlap.

Optional Feature:
- Macro: APPROX_DIV_ROUND_EN.
- Defined:
  - A sticky register captures the last bit shifted out during right shifts.
  - At the end of SHIFT, Q = shifted q + that bit, i.e. round half up (round to nearest, ties away from zero).
  - No effect when e>=0.
- Undefined: right shifts truncate toward zero. No extra register or adder is built.
- Latency is identical in both builds.

Test Plan:
- Typical division. Stimulus: A=100, B=7.
  - Expected internals: shA=9, shB=13, Ah=200, Bh=224, q=228, e=-4.
  - Required: Q=14, div_by_zero=0.
  - Required latency: 1+14+16+4+1 = 36 cycles.
- Maximum dividend, minimum divisor. Stimulus: A=16'hFFFF, B=1.
  - Expected internals: q=510, e=+7.
  - Required: Q=16'hFF00 (left-shift path, no overflow).
- Rounding case. Stimulus: A=15, B=2.
  - Expected internals: q=480, e=-6.
  - Required without APPROX_DIV_ROUND_EN: Q=7.
  - Required with APPROX_DIV_ROUND_EN: Q=8.
- Zero operands and underflow:
  - B=0 (A=5): done after 2 cycles, Q=16'hFFFF, div_by_zero=1.
  - A=0 (B=9): done after 2 cycles, Q=0.
  - A=1, B=16'hFFFF: e=-23, Q=0.
- Equal operands. Stimulus: A=B=16'h8000.
  - Expected: NORM lasts 1 cycle, q=256, e=-8.
  - Required: Q=1, total latency 27 cycles.
- Reset and handshake:
  - Assert rst low during DIV: outputs return to 0 immediately, no done.
  - Toggle start while busy: ignored.
  - After reset, A=100, B=7 again gives Q=14.
